// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel pipeline: handshakes upstream pixels into
// the line buffer, tracks the raster position and flags the valid windows.
module sobel_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 128,
    parameter int IMG_HEIGHT = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          lb_valid_in,
    output logic [DATA_WIDTH-1:0]         lb_din,
    input  logic                          lb_line_valid,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]  col,
    output logic [$clog2(IMG_HEIGHT)-1:0] row,
    output logic                          sof,
    output logic                          eol,
    output logic                          eof,
    output logic                          busy,
    output logic                          done,
    output logic                          lb_err,
    output logic [15:0]                   frame_cnt
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             lb_err_q, lb_err_d;

    logic accept;
    logic last_pix;
    logic in_window;

    // Handshake, strobes and window markers, all combinational on current position
    always_comb begin
        s_ready     = (state_q == STREAM) && m_ready;
        accept      = s_valid && s_ready;
        last_pix    = (col_q == COL_LAST) && (row_q == ROW_LAST);
        in_window   = (col_q >= COL_TWO) && (row_q >= ROW_TWO);
        lb_valid_in = accept;
        lb_din      = s_data;
        m_valid     = accept && in_window;
        sof         = m_valid && (col_q == COL_TWO) && (row_q == ROW_TWO);
        eol         = m_valid && (col_q == COL_LAST);
        eof         = m_valid && last_pix;
        busy        = (state_q == STREAM);
        done        = (state_q == DONE);
        col         = col_q;
        row         = row_q;
        frame_cnt   = frame_cnt_q;
        lb_err      = lb_err_q;
    end

    // Next-state, raster position, frame counter and sticky error
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        lb_err_d    = lb_err_q | (accept && (row_q >= ROW_TWO) && !lb_line_valid);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            STREAM: begin
                // abort outranks the final-pixel transition to DONE
                if (abort) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (last_pix) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            frame_cnt_q <= '0;
            lb_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            lb_err_q    <= lb_err_d;
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on an 8x4 frame.
module tb_sobel_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, s_valid, m_ready, lb_line_valid;
    logic        s_ready, lb_valid_in, m_valid, sof, eol, eof, busy, done, lb_err;
    logic [7:0]  s_data, lb_din;
    logic [2:0]  col;
    logic [1:0]  row;
    logic [15:0] frame_cnt;

    int n_chk = 0;
    int n_err = 0;
    int acc_n, win_n, sof_at, sof_n, eol_a, eol_b, eol_n, eof_at, eof_n;
    int done_n, order_err, pos_err, din_err, strobe_err;

    sobel_frame_ctrl #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .lb_valid_in(lb_valid_in), .lb_din(lb_din), .lb_line_valid(lb_line_valid),
        .m_valid(m_valid), .m_ready(m_ready), .col(col), .row(row),
        .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done),
        .lb_err(lb_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_mon();
        acc_n = 0; win_n = 0; sof_at = -1; sof_n = 0; eol_a = -1; eol_b = -1; eol_n = 0;
        eof_at = -1; eof_n = 0; done_n = 0; order_err = 0; pos_err = 0; din_err = 0;
        strobe_err = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        lb_line_valid = 1'b1; s_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
    endtask

    // One clock: drive at negedge, observe 1ns later, record events
    task automatic cyc(input logic st, input logic ab, input logic sv, input logic mr);
        int p, expw;
        @(negedge clk);
        start = st; abort = ab; s_valid = sv; m_ready = mr;
        s_data = 8'((acc_n % 32) * 37 + 5);
        #1;
        if (s_ready && !mr) strobe_err++;
        if (!lb_valid_in && (m_valid || sof || eol || eof)) strobe_err++;
        if (done) done_n++;
        if (lb_valid_in) begin
            if (!(sv && mr)) strobe_err++;
            if (lb_din !== s_data) din_err++;
            p = acc_n % 32;
            if (int'(col) != p % 8 || int'(row) != p / 8) pos_err++;
            acc_n++;
            if (m_valid) begin
                expw = (2 + win_n / 6) * 8 + 2 + win_n % 6;
                if (int'(row) * 8 + int'(col) != expw) order_err++;
                win_n++;
            end
            if (sof) begin sof_at = acc_n; sof_n++; end
            if (eol) begin
                if (eol_n == 0) eol_a = acc_n;
                else if (eol_n == 1) eol_b = acc_n;
                eol_n++;
            end
            if (eof) begin eof_at = acc_n; eof_n++; end
        end
    endtask

    // Feed pixels until n have been accepted; gap is the percent chance of an idle beat
    task automatic stream_to(input int n, input int gap);
        int   budget;
        logic sv;
        budget = 0;
        while (acc_n < n && budget < 400) begin
            sv = (gap == 0) ? 1'b1 : ($urandom_range(99, 0) >= gap);
            cyc(1'b0, 1'b0, sv, 1'b1);
            budget++;
        end
        if (acc_n < n) chk("stream_timeout", acc_n, n);
    endtask

    task automatic frame_checks(input string t);
        chk({t, "_accepts"}, acc_n, 32);
        chk({t, "_windows"}, win_n, 12);
        chk({t, "_sof_at"}, sof_at, 19);
        chk({t, "_sof_n"}, sof_n, 1);
        chk({t, "_eol_n"}, eol_n, 2);
        chk({t, "_eol_a"}, eol_a, 24);
        chk({t, "_eol_b"}, eol_b, 32);
        chk({t, "_eof_at"}, eof_at, 32);
        chk({t, "_eof_n"}, eof_n, 1);
        chk({t, "_win_order"}, order_err, 0);
        chk({t, "_col_row"}, pos_err, 0);
        chk({t, "_lb_din"}, din_err, 0);
        chk({t, "_strobes"}, strobe_err, 0);
    endtask

    // Observe the DONE cycle (optionally with a start pulse) and the following IDLE
    task automatic finish_frame(input string t, input logic st_in_done, input int exp_cnt);
        cyc(st_in_done, 1'b0, 1'b1, 1'b1);
        chk({t, "_done_pulse"}, done, 1);
        chk({t, "_done_busy"}, busy, 0);
        chk({t, "_done_s_ready"}, s_ready, 0);
        chk({t, "_done_no_accept"}, lb_valid_in, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk({t, "_done_end"}, done, 0);
        chk({t, "_idle_busy"}, busy, 0);
        chk({t, "_frame_cnt"}, frame_cnt, exp_cnt);
        chk({t, "_done_count"}, done_n, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state, with a pixel offered while idle
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_lb_valid", lb_valid_in, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_lb_err", lb_err, 0);

        // Back-to-back frame
        clear_mon();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_busy", busy, 1);
        stream_to(32, 0);
        frame_checks("b2b");
        finish_frame("b2b", 1'b0, 1);
        chk("b2b_lb_err", lb_err, 0);

        // start pulsed in STREAM and in DONE is ignored
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        stream_to(5, 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        stream_to(32, 0);
        frame_checks("restart");
        finish_frame("restart", 1'b1, 1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("restart_still_idle", busy, 0);
        chk("restart_single_done", done_n, 1);

        // Random upstream gaps plus a 5-cycle downstream stall mid-row
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        stream_to(12, 30);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            chk("stall_s_ready", s_ready, 0);
            chk("stall_col", col, 4);
            chk("stall_row", row, 1);
        end
        stream_to(32, 30);
        frame_checks("gaps");
        finish_frame("gaps", 1'b0, 1);

        // Abort after 10 accepts
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        stream_to(10, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_col", col, 0);
        chk("abort_row", row, 0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_no_done", done_n, 0);
        chk("abort_frame_cnt", frame_cnt, 0);
        clear_mon();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        stream_to(32, 0);
        frame_checks("post_abort");
        finish_frame("post_abort", 1'b0, 1);

        // abort in IDLE is ignored; abort on the final pixel beats DONE
        clear_mon();
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("idle_abort_ignored", busy, 1);
        stream_to(31, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("last_abort_accept", acc_n, 32);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("last_abort_done", done, 0);
        chk("last_abort_busy", busy, 0);
        chk("last_abort_col", col, 0);
        chk("last_abort_row", row, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("last_abort_no_done", done_n, 0);
        chk("last_abort_frame_cnt", frame_cnt, 1);

        // lb_line_valid low: harmless in rows 0-1, sets sticky error at row 2
        do_reset();
        lb_line_valid = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        stream_to(17, 0);
        chk("lberr_rows01", lb_err, 0);
        @(posedge clk);
        #1;
        lb_line_valid = 1'b1;
        chk("lberr_set", lb_err, 1);
        stream_to(32, 0);
        frame_checks("lberr");
        finish_frame("lberr", 1'b0, 1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("lberr_sticky", lb_err, 1);
        do_reset();
        #1;
        chk("lberr_cleared", lb_err, 0);

        // Asynchronous reset in the middle of a frame
        clear_mon();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        stream_to(32, 0);
        finish_frame("pre_rst", 1'b0, 1);
        clear_mon();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        stream_to(12, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_lb_valid", lb_valid_in, 0);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_markers", {29'd0, sof, eol, eof}, 0);
        chk("arst_col", col, 0);
        chk("arst_row", row, 0);
        chk("arst_done", done, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("arst_idle", busy, 0);
        chk("arst_no_done", done_n, 0);
        chk("arst_no_accept", acc_n, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
